voice_read_scheduler: RTL and testbench
=======================================

// Module: voice_read_scheduler
// PURPOSE
//  Time-multiplexes one wavetable BRAM read port among active voices. Each sample_tick_in
//  reads one table word per active voice and sums them into one mixed sample.
//  Sits between the per-note address generator outputs and the audio output path.
// PARAMETERS
//  ADDR_WIDTH      8   wavetable address width
//  DATA_WIDTH      8   signed wavetable word width
//  NUM_NOTES       24  note slots in addr_in
//  NUM_VOICES      8   max simultaneous voices (power of 2)
//  NUM_NOTES_WIDTH 5   note index width
//  BRAM_LATENCY    2   cycles from bram_addr_out change to valid bram_data_in (1..4)
// PORTS
//  clk_in             in   1                      system clock
//  rst_n_in           in   1                      async active-low reset
//  sample_tick_in     in   1                      1-cycle pulse: start one mix
//  addr_in            in   ADDR_WIDTH x NUM_NOTES per-note table address
//  active_voices_idx_in in NUM_NOTES_WIDTH x NUM_VOICES note index per voice slot
//  num_voices_in      in   4                      valid slot count
//  bram_addr_out      out  ADDR_WIDTH             registered BRAM read address
//  bram_data_in       in   DATA_WIDTH             signed BRAM read data
//  sample_out         out  DATA_WIDTH+3           signed mixed sample, held until next valid
//  sample_valid_out   out  1                      1-cycle pulse, sample_out updated
//  busy_out           out  1                      high in ISSUE/DRAIN
//  overrun_out        out  1                      sticky: tick arrived while busy
// BEHAVIOUR
//  Clock/reset: one clock clk_in; reset rst_n_in is asynchronous, active-low.
//  Reset: all outputs 0, state IDLE, accumulator 0, delay pipe cleared. Asserting reset mid-mix aborts it.
//  FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  Tick accepted in IDLE or DONE (cycle T): snapshot N = min(num_voices_in, NUM_VOICES).
//  Also snapshot slot indices 0..N-1. Clear accumulator.
//  Go to ISSUE if N>0. If N=0, go to DONE: sample_out=0, valid at T+1.
//  ISSUE: slot k address (addr_in[idx_k], live value) registered; visible cycle T+1+k.
//  After slot N-1, go to DRAIN.
//  Slots with idx >= NUM_NOTES (e.g. 5'b11111): drive address 0, tag invalid, contribute 0, still use a slot.
//  Data for slot k sampled at end of cycle T+1+k+BRAM_LATENCY via tagged valid delay line.
//  Sign-extend to DATA_WIDTH+3 and add. Cannot overflow.
//  DRAIN: hold until last tagged valid exits the delay line. Then DONE.
//  DONE: 1 cycle; sample_out <= acc, sample_valid_out=1; valid cycle = T+N+BRAM_LATENCY+1.
//  Tick while busy_out=1: ignored; overrun_out set, cleared only by reset.
//  bram_addr_out holds last value outside ISSUE.
// CONFIGURATION
//  VOICE_NORM_EN defined: sample_out = acc >>> s, with sign kept.
//    s=0 for N<=1, 1 for N=2, 2 for N=3..4, 3 for N=5..8.
//  VOICE_NORM_EN undefined: sample_out = raw acc.
// STRUCTURE
//  synth_pkg: NUM_NOTES_WIDTH, INVALID_IDX=5'b11111, sched_state_t enum.
//  synth_pkg also holds the norm_shift(N) function.
//  Sub-module bram_latency_pipe: BRAM_LATENCY-deep shift of {valid, contributes} tags.
// TESTING
//  Setup for all cases: BRAM returns addr as data, signed, 2-cycle latency.
//  N=3, idx {0,5,23}, addr {10,20,30}: valid at T+6, sample_out=60.
//  N=0 tick -> valid at T+1, sample_out=0, no bram_addr_out change.
//  N=8, all data -128: sample_out=-1024 (no VOICE_NORM_EN); -128 with VOICE_NORM_EN.
//  Slot idx 5'b11111 among N=2, other addr 7: sample_out=7; valid at T+5.
//  Tick at T+2 during N=4 mix: ignored, overrun_out=1 until reset, first result intact.
//  Back-to-back: tick in DONE cycle is accepted.
//  Reset pulse mid-ISSUE: all outputs 0 immediately; next tick produces a correct sum.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types, constants and the voice-count scaling helper for the voice scheduler
package synth_pkg;

  localparam int NUM_NOTES_WIDTH = 5;
  localparam logic [NUM_NOTES_WIDTH-1:0] INVALID_IDX = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic valid;
    logic contrib;
  } slot_tag_t;

  function automatic logic [1:0] norm_shift(input logic [3:0] n);
    if (n <= 4'd1)      return 2'd0;
    else if (n == 4'd2) return 2'd1;
    else if (n <= 4'd4) return 2'd2;
    else                return 2'd3;
  endfunction

endpackage

// File: rtl/bram_latency_pipe.sv
// rtl/bram_latency_pipe.sv - delays per-slot tags so they line up with BRAM read data
module bram_latency_pipe
  import synth_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  slot_tag_t tag_in,
  output slot_tag_t tag_out
);

  slot_tag_t r_pipe [DEPTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign tag_out = r_pipe[DEPTH-1];

endmodule

// File: rtl/voice_read_scheduler.sv
// rtl/voice_read_scheduler.sv - shares one wavetable BRAM read port across voices, one mixed sample per tick
// VOICE_NORM_EN: when defined, the mixed sample is scaled down according to the voice count.
module voice_read_scheduler
  import synth_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_NOTES    = 24,
  parameter int NUM_VOICES   = 8,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  input  logic                                         sample_tick_in,
  input  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0]         addr_in,
  input  logic [NUM_VOICES-1:0][NUM_NOTES_WIDTH-1:0]   active_voices_idx_in,
  input  logic [3:0]                                   num_voices_in,
  output logic [ADDR_WIDTH-1:0]                        bram_addr_out,
  input  logic signed [DATA_WIDTH-1:0]                 bram_data_in,
  output logic signed [DATA_WIDTH+2:0]                 sample_out,
  output logic                                         sample_valid_out,
  output logic                                         busy_out,
  output logic                                         overrun_out
);

  localparam int SW     = DATA_WIDTH + 3;
  localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  sched_state_t                               r_state;
  logic [3:0]                                 r_n;
  logic [3:0]                                 r_remaining;
  logic [SLOT_W-1:0]                          r_slot;
  logic [NUM_VOICES-1:0][NUM_NOTES_WIDTH-1:0] r_idx;
  logic signed [SW-1:0]                       r_acc;
  slot_tag_t                                  r_tag;

  slot_tag_t                  w_tag_out;
  logic [3:0]                 w_n_snap;
  logic [SLOT_W-1:0]          w_next_slot;
  logic [NUM_NOTES_WIDTH-1:0] w_sel_idx;
  logic                       w_sel_ok;
  logic [ADDR_WIDTH-1:0]      w_sel_addr;
  logic signed [SW-1:0]       w_add;
  logic signed [SW-1:0]       w_acc_next;
  logic signed [SW-1:0]       w_result;

  // Slot 0 is issued on the tick edge itself, so it reads the live index instead of the snapshot.
  always_comb begin
    w_n_snap    = (num_voices_in > 4'(NUM_VOICES)) ? 4'(NUM_VOICES) : num_voices_in;
    w_next_slot = r_slot + SLOT_W'(1);
    w_sel_idx   = (r_state == S_ISSUE) ? r_idx[w_next_slot] : active_voices_idx_in[0];
    w_sel_ok    = (w_sel_idx != INVALID_IDX) && (int'(w_sel_idx) < NUM_NOTES);
    w_sel_addr  = w_sel_ok ? addr_in[w_sel_idx] : '0;
    w_add       = (w_tag_out.valid && w_tag_out.contrib) ? SW'(bram_data_in) : '0;
    w_acc_next  = r_acc + w_add;
`ifdef VOICE_NORM_EN
    w_result    = w_acc_next >>> norm_shift(r_n);
`else
    w_result    = w_acc_next;
`endif
  end

  bram_latency_pipe #(
    .DEPTH (BRAM_LATENCY)
  ) u_pipe (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tag_in   (r_tag),
    .tag_out  (w_tag_out)
  );

  assign busy_out = (r_state == S_ISSUE) || (r_state == S_DRAIN);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state          <= S_IDLE;
      r_n              <= '0;
      r_remaining      <= '0;
      r_slot           <= '0;
      r_idx            <= '0;
      r_acc            <= '0;
      r_tag            <= '0;
      bram_addr_out    <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      r_tag            <= '0;
      if (w_tag_out.valid) begin
        r_acc       <= w_acc_next;
        r_remaining <= r_remaining - 4'd1;
      end
      if (sample_tick_in && busy_out) overrun_out <= 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (sample_tick_in) begin
            r_n         <= w_n_snap;
            r_remaining <= w_n_snap;
            r_idx       <= active_voices_idx_in;
            r_acc       <= '0;
            r_slot      <= '0;
            if (w_n_snap == 4'd0) begin
              sample_out       <= '0;
              sample_valid_out <= 1'b1;
              r_state          <= S_DONE;
            end else begin
              bram_addr_out <= w_sel_addr;
              r_tag         <= '{valid: 1'b1, contrib: w_sel_ok};
              r_state       <= S_ISSUE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (r_slot == SLOT_W'(r_n - 4'd1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_slot        <= w_next_slot;
            bram_addr_out <= w_sel_addr;
            r_tag         <= '{valid: 1'b1, contrib: w_sel_ok};
          end
        end
        S_DRAIN: begin
          if (w_tag_out.valid && (r_remaining == 4'd1)) begin
            sample_out       <= w_result;
            sample_valid_out <= 1'b1;
            r_state          <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_read_scheduler.sv
// tb/tb_voice_read_scheduler.sv - scoreboard bench for voice_read_scheduler with a 2-cycle echo BRAM
module tb_voice_read_scheduler;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NN  = 24;
  localparam int NV  = 8;
  localparam int LAT = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     tick = 1'b0;
  logic [NN-1:0][AW-1:0]    addr;
  logic [NV-1:0][4:0]       idx;
  logic [3:0]               nv;
  logic [AW-1:0]            bram_addr;
  logic signed [DW-1:0]     bram_data;
  logic signed [DW+2:0]     sample;
  logic                     valid;
  logic                     busy;
  logic                     overrun;
  logic [AW-1:0]            d1;
  logic [AW-1:0]            d2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1  <= bram_addr;
    d2  <= d1;
  end
  assign bram_data = d2;

  voice_read_scheduler #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_NOTES    (NN),
    .NUM_VOICES   (NV),
    .BRAM_LATENCY (LAT)
  ) dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .sample_tick_in       (tick),
    .addr_in              (addr),
    .active_voices_idx_in (idx),
    .num_voices_in        (nv),
    .bram_addr_out        (bram_addr),
    .bram_data_in         (bram_data),
    .sample_out           (sample),
    .sample_valid_out     (valid),
    .busy_out             (busy),
    .overrun_out          (overrun)
  );

  function automatic int model(input int n);
    int s;
    int m;
    s = 0;
    m = (n > NV) ? NV : n;
    for (int k = 0; k < m; k++)
      if (int'(idx[k]) < NN) s += int'($signed(addr[idx[k]]));
`ifdef VOICE_NORM_EN
    if (m == 2)      s = s >>> 1;
    else if (m >= 5) s = s >>> 3;
    else if (m >= 3) s = s >>> 2;
`endif
    return s;
  endfunction

  function automatic int latency(input int n);
    int m;
    m = (n > NV) ? NV : n;
    return (m == 0) ? 1 : m + LAT + 1;
  endfunction

  task automatic fire(input int n);
    exp_t e;
    nv    = 4'(n);
    tick  = 1'b1;
    e.val = model(n);
    e.due = cyc + latency(n);
    sb.push_back(e);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic push_tick(input int n);
    @(negedge clk);
    fire(n);
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (valid) begin
        got = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s: unexpected sample_valid_out, sample=%0d", name, sample);
        end else begin
          e = sb.pop_front();
          if (int'(sample) !== e.val) begin
            errors++;
            $display("FAIL %s sample: got %0d expected %0d", name, sample, e.val);
          end
          checks++;
          if (cyc !== e.due) begin
            errors++;
            $display("FAIL %s timing: valid at cycle %0d expected %0d", name, cyc, e.due);
          end
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no sample_valid_out within 40 cycles", name);
    end
  endtask

  task automatic set_basic();
    addr[0]  = 8'd10;
    addr[5]  = 8'd20;
    addr[23] = 8'd30;
    idx      = '0;
    idx[0]   = 5'd0;
    idx[1]   = 5'd5;
    idx[2]   = 5'd23;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (sample !== '0)    begin errors++; $display("FAIL reset sample: got %0d expected 0", sample); end
    if (valid !== 1'b0)   begin errors++; $display("FAIL reset valid: got %b expected 0", valid); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b expected 0", overrun); end
    if (bram_addr !== '0) begin errors++; $display("FAIL reset bram_addr: got %0d expected 0", bram_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_basic();
    push_tick(3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic busy: got %b expected 1", busy); end
    wait_result("basic_n3");
  endtask

  task automatic test_zero_voices();
    push_tick(0);
    wait_result("zero_voices");
    checks += 2;
    if (bram_addr !== 8'd30) begin errors++; $display("FAIL zero bram_addr: got %0d expected 30", bram_addr); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL zero busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_negative();
    for (int k = 0; k < NV; k++) begin
      addr[k] = 8'h80;
      idx[k]  = 5'(k);
    end
    push_tick(8);
    wait_result("full_neg_n8");
    push_tick(12);
    wait_result("full_neg_clamped");
  endtask

  task automatic test_invalid_slot();
    addr[3] = 8'd7;
    idx     = '0;
    idx[0]  = 5'b11111;
    idx[1]  = 5'd3;
    push_tick(2);
    wait_result("invalid_slot");
  endtask

  task automatic test_overrun();
    for (int k = 0; k < 4; k++) begin
      addr[k+1] = 8'(k + 1);
      idx[k]    = 5'(k + 1);
    end
    push_tick(4);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun set: got %b expected 1", overrun); end
    wait_result("overrun_first");
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (valid) seen = 1'b1;
      end
      checks += 2;
      if (seen)             begin errors++; $display("FAIL overrun extra: got extra valid expected none"); end
      if (overrun !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %b expected 1", overrun); end
    end
  endtask

  task automatic test_back_to_back();
    set_basic();
    push_tick(3);
    wait_result("b2b_first");
    idx    = '0;
    idx[0] = 5'd5;
    idx[1] = 5'd23;
    fire(2);
    wait_result("b2b_second");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) idx[k] = 5'(k + 1);
    @(negedge clk);
    nv   = 4'd4;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bram_addr !== '0) begin errors++; $display("FAIL rstmid bram_addr: got %0d expected 0", bram_addr); end
    if (sample !== '0)    begin errors++; $display("FAIL rstmid sample: got %0d expected 0", sample); end
    if (valid !== 1'b0)   begin errors++; $display("FAIL rstmid valid: got %b expected 0", valid); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid busy: got %b expected 0", busy); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid overrun: got %b expected 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    set_basic();
    push_tick(3);
    wait_result("after_reset");
  endtask

  initial begin
    for (int k = 0; k < NN; k++) addr[k] = 8'(k);
    idx = '0;
    nv  = 4'd0;
    test_reset();
    test_basic();
    test_zero_voices();
    test_full_negative();
    test_invalid_slot();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover: %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
